multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Multi-cycle MIPS control FSM. Successor to the single-cycle combinational decoder.
//  Sequences FETCH/DECODE/EXEC/MEM/WB per instruction and handshakes with memory via
//  mem_ready. Traps on illegal opcode/funct and on memory timeout. Counts retired
//  instructions. Sits between the IR (op_in/func_in) and the shared-memory datapath.
// PARAMETERS
//  MEM_TIMEOUT  16  max consecutive wait cycles in a memory state before trap; 0 = never trap
//  COUNT_W      32  width of retired-instruction counter
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   reset, asynchronous assert, active-low
//  op_in        in   6   IR[31:26]; stable from DECODE until next ir_write
//  func_in      in   6   IR[5:0]
//  mem_ready    in   1   memory completes read/write this cycle
//  pc_write     out  1   unconditional PC load
//  pc_write_cond out 1   PC load if ALU zero (BEQ)
//  i_or_d       out  1   0 = PC addresses memory, 1 = ALUOut
//  mem_read     out  1   memory read request
//  mem_write    out  1   memory write request
//  ir_write     out  1   IR load strobe
//  mem_to_reg   out  1   write-back source: 1 = MDR, 0 = ALUOut
//  reg_dst      out  1   1 = rd, 0 = rt
//  reg_write    out  1   register-file write
//  alu_src_a    out  1   0 = PC, 1 = reg A
//  alu_src_b    out  2   00 = reg B, 01 = 4, 10 = sext imm, 11 = sext imm<<2
//  alu_op       out  2   00 = add, 01 = sub, 10 = funct-decoded
//  pc_source    out  2   00 = ALU result, 01 = ALUOut, 10 = jump target
//  instr_done   out  1   one-cycle pulse in the cycle an instruction retires
//  instr_count  out  COUNT_W  retired instructions, wraps modulo 2^COUNT_W
//  trap         out  1   sticky halt flag
//  trap_cause   out  2   00 = none, 01 = illegal op/funct, 10 = memory timeout
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, wait_cnt=0, instr_count=0, trap=0, trap_cause=00;
//   every control output 0. Reset mid-instruction aborts it; nothing retires.
//  Control outputs are a function of state (and mem_ready for the FETCH strobes); unlisted outputs = 0.
//  IDLE: -> FETCH unconditionally.
//  FETCH: mem_read=1, i_or_d=0, alu_src_b=01, alu_op=00, pc_source=00.
//   Asserts ir_write=pc_write=mem_ready. -> DECODE when mem_ready=1, else stays.
//  DECODE: alu_src_b=11, alu_op=00 (branch target).
//   LW(100011)/SW(101011) -> MEM_ADDR; ADDI(001000) -> ADDI_EXEC; BEQ(000100) -> BRANCH;
//   J(000010) -> JUMP; op=0,func=0 (NOP) -> FETCH, retires.
//   op=0, func in {100000,100010,100100,100101,101010} -> R_EXEC. Any other -> TRAP, cause 01.
//  MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. -> MEM_READ (LW) / MEM_WRITE (SW).
//  MEM_READ: mem_read=1, i_or_d=1. -> MEM_WB on mem_ready.
//  MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. -> FETCH, retires.
//  MEM_WRITE: mem_write=1, i_or_d=1. -> FETCH on mem_ready, retires.
//  R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. -> R_WB.
//  R_WB: reg_write=1, reg_dst=1. -> FETCH, retires.
//  ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00. -> ADDI_WB.
//  ADDI_WB: reg_write=1, reg_dst=0. -> FETCH, retires.
//  BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01. -> FETCH, retires.
//  JUMP: pc_write=1, pc_source=10. -> FETCH, retires.
//  TRAP: all control outputs 0; trap=1; stays until reset.
//  Retire: instr_done=1 in the last cycle of the instruction; instr_count++ on that edge, wraps silently.
//  Zero-wait cycle counts: R/ADDI/LW = 4/4/5 incl FETCH; SW/BEQ/J = 4/3/3; NOP = 2.
//  Memory wait: wait_cnt clears on entering FETCH/MEM_READ/MEM_WRITE and increments each
//   cycle with mem_ready=0. If mem_ready=0 with wait_cnt==MEM_TIMEOUT-1 -> TRAP, cause 10.
//   mem_ready in that same cycle wins (no trap). Ignored outside memory states.
// TESTING
//  Reset, release, ADD (op 0, func 100000), mem_ready=1 -> IDLE,FETCH,DECODE,R_EXEC,R_WB;
//   reg_dst=reg_write=1 in R_WB; instr_done pulse; instr_count=1.
//  LW, mem_ready low 3 cycles in MEM_READ -> mem_read,i_or_d held 4 cycles; MEM_WB mem_to_reg=1; count+1.
//  op=111111 or op 0/func 000001 -> TRAP, trap_cause=01, outputs 0, stays 20 cycles; rst_n=0 clears.
//  mem_ready stuck 0 in FETCH, MEM_TIMEOUT=16 -> TRAP cause 10 on the 16th wait cycle; ready on 16th -> no trap.
//  BEQ then J then NOP -> pc_write_cond/pc_source=01, pc_write/pc_source=10, NOP in 2 cycles; count+3.
//  COUNT_W=3, 9 NOPs -> instr_count 1; rst_n pulse mid-LW in MEM_READ -> IDLE, count 0, no reg_write.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, handshakes with
// memory via mem_ready, traps on illegal instructions or memory timeout, counts retirements.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | post-reset bubble, moves to FETCH
// FETCH     | read instruction at PC, PC += 4 when memory ready
// DECODE    | register read, branch target computed
// MEM_ADDR  | LW/SW effective address
// MEM_READ  | LW data read, waits on mem_ready
// MEM_WB    | LW write-back from MDR
// MEM_WRITE | SW data write, waits on mem_ready
// R_EXEC    | R-type ALU operation
// R_WB      | R-type write-back to rd
// ADDI_EXEC | ADDI ALU operation
// ADDI_WB   | ADDI write-back to rt
// BRANCH    | BEQ compare and conditional PC load
// JUMP      | J target PC load
// TRAP      | halted until reset
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int COUNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op_in,
    input  logic [5:0]         func_in,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               instr_done,
    output logic [COUNT_W-1:0] instr_count,
    output logic               trap,
    output logic [1:0]         trap_cause
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_MEM_ADDR  = 4'd3;
    localparam logic [3:0] S_MEM_READ  = 4'd4;
    localparam logic [3:0] S_MEM_WB    = 4'd5;
    localparam logic [3:0] S_MEM_WRITE = 4'd6;
    localparam logic [3:0] S_R_EXEC    = 4'd7;
    localparam logic [3:0] S_R_WB      = 4'd8;
    localparam logic [3:0] S_ADDI_EXEC = 4'd9;
    localparam logic [3:0] S_ADDI_WB   = 4'd10;
    localparam logic [3:0] S_BRANCH    = 4'd11;
    localparam logic [3:0] S_JUMP      = 4'd12;
    localparam logic [3:0] S_TRAP      = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam int              WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam bit              TIMEOUT_EN = (MEM_TIMEOUT > 0);

    logic [3:0]         state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               trap_q, trap_d;
    logic [1:0]         cause_q, cause_d;
    logic               retire;
    logic               timeout_hit;
    logic               mem_state;
    logic               r_func_ok;

    assign timeout_hit = TIMEOUT_EN && !mem_ready && (wait_cnt_q == WAIT_LAST);
    assign mem_state   = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);

    always_comb begin
        unique case (func_in)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: r_func_ok = 1'b1;
            default:                                               r_func_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        trap_d  = trap_q;
        cause_d = cause_q;
        retire  = 1'b0;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (op_in)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_RTYPE: begin
                        if (func_in == 6'b000000) begin
                            state_d = S_FETCH;
                            retire  = 1'b1;
                        end else if (r_func_ok) begin
                            state_d = S_R_EXEC;
                        end else begin
                            state_d = S_TRAP;
                            trap_d  = 1'b1;
                            cause_d = CAUSE_ILLEGAL;
                        end
                    end
                    default: begin
                        state_d = S_TRAP;
                        trap_d  = 1'b1;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEM_ADDR: state_d = (op_in == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: begin
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_MEM_WRITE: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_R_EXEC:    state_d = S_R_WB;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_IDLE;
        endcase
    end

    // Wait counter only runs while a memory state keeps waiting; any transition clears it.
    assign wait_cnt_d = (mem_state && !mem_ready && (state_d == state_q))
                        ? wait_cnt_q + WAIT_W'(1) : '0;
    assign count_d    = retire ? count_q + COUNT_W'(1) : count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            count_q    <= '0;
            trap_q     <= 1'b0;
            cause_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            count_q    <= count_d;
            trap_q     <= trap_d;
            cause_q    <= cause_d;
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEM_ADDR, S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_ADDI_WB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            default: ;
        endcase
    end

    assign instr_done  = retire;
    assign instr_count = count_q;
    assign trap        = trap_q;
    assign trap_cause  = cause_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: a 32-bit-counter instance and a 3-bit-counter
// instance share stimulus; control vectors are compared against hand-written per-state values.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op_in;
    logic [5:0] func_in;
    logic       mem_ready;

    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, trap;
    logic [1:0]  alu_src_b, alu_op, pc_source, trap_cause;
    logic [31:0] instr_count;

    logic        pc_write_b, pc_write_cond_b, i_or_d_b, mem_read_b, mem_write_b, ir_write_b;
    logic        mem_to_reg_b, reg_dst_b, reg_write_b, alu_src_a_b, instr_done_b, trap_b;
    logic [1:0]  alu_src_b_b, alu_op_b, pc_source_b, trap_cause_b;
    logic [2:0]  instr_count_b;

    logic [16:0] ctrl, ctrl_b;

    int checks = 0;
    int errors = 0;
    int model_cnt = 0;

    // Bit order: pcw pcwc iord mrd mwr irw m2r rdst rw asa asb[1:0] aop[1:0] ps[1:0] done
    localparam logic [16:0] E_ZERO      = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] E_FETCH_R   = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [16:0] E_FETCH_W   = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] E_DECODE    = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] E_DEC_NOP   = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
    localparam logic [16:0] E_MEM_ADDR  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] E_MEM_READ  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] E_MEM_WB    = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_1;
    localparam logic [16:0] E_MEM_WRITE = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_1;
    localparam logic [16:0] E_R_EXEC    = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] E_R_WB      = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_1;
    localparam logic [16:0] E_ADDI_WB   = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_1;
    localparam logic [16:0] E_BRANCH    = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_1;
    localparam logic [16:0] E_JUMP      = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_1;

    assign ctrl   = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                     reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done};
    assign ctrl_b = {pc_write_b, pc_write_cond_b, i_or_d_b, mem_read_b, mem_write_b, ir_write_b,
                     mem_to_reg_b, reg_dst_b, reg_write_b, alu_src_a_b, alu_src_b_b, alu_op_b,
                     pc_source_b, instr_done_b};

    multicycle_control_unit #(.MEM_TIMEOUT(16), .COUNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .op_in(op_in), .func_in(func_in), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .instr_done(instr_done), .instr_count(instr_count), .trap(trap), .trap_cause(trap_cause)
    );

    multicycle_control_unit #(.MEM_TIMEOUT(16), .COUNT_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .op_in(op_in), .func_in(func_in), .mem_ready(mem_ready),
        .pc_write(pc_write_b), .pc_write_cond(pc_write_cond_b), .i_or_d(i_or_d_b),
        .mem_read(mem_read_b), .mem_write(mem_write_b), .ir_write(ir_write_b),
        .mem_to_reg(mem_to_reg_b), .reg_dst(reg_dst_b), .reg_write(reg_write_b),
        .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b), .alu_op(alu_op_b),
        .pc_source(pc_source_b), .instr_done(instr_done_b), .instr_count(instr_count_b),
        .trap(trap_b), .trap_cause(trap_cause_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [16:0] exp_ctrl,
                           input logic exp_trap, input logic [1:0] exp_cause);
        chk({tag, " ctrl"}, {15'b0, ctrl}, {15'b0, exp_ctrl});
        chk({tag, " ctrl3"}, {15'b0, ctrl_b}, {15'b0, exp_ctrl});
        chk({tag, " trap"}, {31'b0, trap}, {31'b0, exp_trap});
        chk({tag, " trap3"}, {31'b0, trap_b}, {31'b0, exp_trap});
        chk({tag, " cause"}, {30'b0, trap_cause}, {30'b0, exp_cause});
        chk({tag, " cause3"}, {30'b0, trap_cause_b}, {30'b0, exp_cause});
    endtask

    task automatic chk_count(input string tag);
        chk({tag, " count"}, instr_count, 32'(model_cnt));
        chk({tag, " count3"}, {29'b0, instr_count_b}, 32'(model_cnt % 8));
    endtask

    // Called at posedge+1: drive mem_ready, check at the falling edge, advance to next posedge+1.
    task automatic cyc(input string tag, input logic [16:0] exp_ctrl, input logic ready,
                       input logic exp_trap = 1'b0, input logic [1:0] exp_cause = 2'b00);
        mem_ready = ready;
        @(negedge clk);
        chk_all(tag, exp_ctrl, exp_trap, exp_cause);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_cnt = 0;
        chk_all(tag, E_ZERO, 1'b0, 2'b00);
        chk_count(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_ir(input logic [5:0] op, input logic [5:0] fn);
        op_in   = op;
        func_in = fn;
    endtask

    initial begin
        rst_n     = 1'b0;
        op_in     = 6'b0;
        func_in   = 6'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset("reset");

        // ADD
        cyc("add idle", E_ZERO, 1'b1);
        set_ir(6'b000000, 6'b100000);
        cyc("add fetch", E_FETCH_R, 1'b1);
        cyc("add decode", E_DECODE, 1'b1);
        cyc("add exec", E_R_EXEC, 1'b1);
        cyc("add wb", E_R_WB, 1'b1);
        model_cnt++;
        chk_count("add");

        // LW with three wait cycles in MEM_READ
        set_ir(6'b100011, 6'b000000);
        cyc("lw fetch", E_FETCH_R, 1'b1);
        cyc("lw decode", E_DECODE, 1'b0);
        cyc("lw addr", E_MEM_ADDR, 1'b0);
        for (int i = 0; i < 3; i++) cyc("lw wait", E_MEM_READ, 1'b0);
        cyc("lw read", E_MEM_READ, 1'b1);
        cyc("lw wb", E_MEM_WB, 1'b0);
        model_cnt++;
        chk_count("lw");

        // SW, ADDI
        set_ir(6'b101011, 6'b000000);
        cyc("sw fetch", E_FETCH_R, 1'b1);
        cyc("sw decode", E_DECODE, 1'b1);
        cyc("sw addr", E_MEM_ADDR, 1'b1);
        cyc("sw write", E_MEM_WRITE, 1'b1);
        set_ir(6'b001000, 6'b111111);
        cyc("addi fetch", E_FETCH_R, 1'b1);
        cyc("addi decode", E_DECODE, 1'b1);
        cyc("addi exec", E_MEM_ADDR, 1'b1);
        cyc("addi wb", E_ADDI_WB, 1'b1);
        model_cnt += 2;
        chk_count("sw addi");

        // BEQ, J, NOP
        set_ir(6'b000100, 6'b000000);
        cyc("beq fetch", E_FETCH_R, 1'b1);
        cyc("beq decode", E_DECODE, 1'b1);
        cyc("beq branch", E_BRANCH, 1'b1);
        set_ir(6'b000010, 6'b000000);
        cyc("j fetch", E_FETCH_R, 1'b1);
        cyc("j decode", E_DECODE, 1'b1);
        cyc("j jump", E_JUMP, 1'b1);
        set_ir(6'b000000, 6'b000000);
        cyc("nop fetch", E_FETCH_R, 1'b1);
        cyc("nop decode", E_DEC_NOP, 1'b1);
        model_cnt += 3;
        chk_count("beq j nop");

        // FETCH ready on the 16th wait cycle: no trap; count reaches 8 (3-bit wraps to 0)
        for (int i = 0; i < 15; i++) cyc("fetch wait", E_FETCH_W, 1'b0);
        cyc("fetch ready16", E_FETCH_R, 1'b1);
        cyc("late nop decode", E_DEC_NOP, 1'b0);
        model_cnt++;
        chk_count("wrap8");

        for (int i = 0; i < 9; i++) begin
            cyc("nop9 fetch", E_FETCH_R, 1'b1);
            cyc("nop9 decode", E_DEC_NOP, 1'b1);
        end
        model_cnt += 9;
        chk_count("nop9");

        // FETCH timeout
        for (int i = 0; i < 16; i++) cyc("timeout wait", E_FETCH_W, 1'b0);
        cyc("timeout trap", E_ZERO, 1'b1, 1'b1, 2'b10);
        chk_count("timeout");
        do_reset("reset after timeout");

        // Illegal opcode, held in TRAP for 20 cycles
        cyc("ill idle", E_ZERO, 1'b1);
        set_ir(6'b111111, 6'b000000);
        cyc("ill fetch", E_FETCH_R, 1'b1);
        cyc("ill decode", E_DECODE, 1'b1);
        for (int i = 0; i < 20; i++) cyc("ill trap", E_ZERO, 1'(i % 2), 1'b1, 2'b01);
        chk_count("ill op");
        do_reset("reset after ill op");

        // Illegal funct
        cyc("illf idle", E_ZERO, 1'b1);
        set_ir(6'b000000, 6'b000001);
        cyc("illf fetch", E_FETCH_R, 1'b1);
        cyc("illf decode", E_DECODE, 1'b1);
        cyc("illf trap", E_ZERO, 1'b1, 1'b1, 2'b01);
        do_reset("reset after ill funct");

        // Reset in the middle of an LW
        cyc("abort idle", E_ZERO, 1'b1);
        set_ir(6'b100011, 6'b000000);
        cyc("abort fetch", E_FETCH_R, 1'b1);
        cyc("abort decode", E_DECODE, 1'b1);
        cyc("abort addr", E_MEM_ADDR, 1'b0);
        cyc("abort read", E_MEM_READ, 1'b0);
        cyc("abort read2", E_MEM_READ, 1'b0);
        mem_ready = 1'b1;
        do_reset("abort reset");
        cyc("abort after idle", E_ZERO, 1'b1);
        cyc("abort after fetch", E_FETCH_R, 1'b1);
        chk_count("abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
